sync_filter: RTL



---
 rtl/sync_filter.sv | 89 ++++++++
 1 files changed

// File: rtl/sync_filter.sv
// Multi-channel input conditioner: per-channel synchroniser, debounce filter and
// registered edge/glitch strobes. Channels share only the clock and reset.
module sync_filter #(
    parameter int   WIDTH         = 1,
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] glitch
);

    localparam int CNT_W = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            // Metastability chain; the attribute keeps the flops distinct and adjacent.
            (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_reg;

            logic             lvl_reg, lvl_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             rise_reg, rise_next;
            logic             fall_reg, fall_next;
            logic             glitch_reg, glitch_next;
            logic             s;

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    sync_reg <= {SYNC_STAGES{RESET_VAL}};
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
                end
            end

            assign s = sync_reg[SYNC_STAGES-1];

            always_comb begin
                lvl_next    = lvl_reg;
                cnt_next    = cnt_reg;
                rise_next   = 1'b0;
                fall_next   = 1'b0;
                glitch_next = 1'b0;
                if (s == lvl_reg) begin
                    // Input fell back before acceptance: drop the pending change.
                    if (cnt_reg != '0) begin
                        cnt_next    = '0;
                        glitch_next = 1'b1;
                    end
                end else if (cnt_reg == CNT_MAX) begin
                    lvl_next  = s;
                    cnt_next  = '0;
                    rise_next = s;
                    fall_next = ~s;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    lvl_reg    <= RESET_VAL;
                    cnt_reg    <= '0;
                    rise_reg   <= 1'b0;
                    fall_reg   <= 1'b0;
                    glitch_reg <= 1'b0;
                end else begin
                    lvl_reg    <= lvl_next;
                    cnt_reg    <= cnt_next;
                    rise_reg   <= rise_next;
                    fall_reg   <= fall_next;
                    glitch_reg <= glitch_next;
                end
            end

            assign out[gi]    = lvl_reg;
            assign rise[gi]   = rise_reg;
            assign fall[gi]   = fall_reg;
            assign glitch[gi] = glitch_reg;
        end
    endgenerate

endmodule
